// File: rtl/ram8x16_pkg.sv
// rtl/ram8x16_pkg.sv - shared sizes and types for the 8x16 register-file RAM
package ram8x16_pkg;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 3;
   localparam int NWORDS = 8;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [NWORDS-1:0] sel_t;

endpackage : ram8x16_pkg

// File: rtl/ram8x16_word.sv
// rtl/ram8x16_word.sv - one storage word, cleared on reset, loaded when enabled
module ram8x16_word
   import ram8x16_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   // Reset wins over a load in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule : ram8x16_word

// File: rtl/ram8x16_core.sv
// rtl/ram8x16_core.sv - 8-word RAM: one-hot decode, eight words, 8:1 read mux
module ram8x16_core
   import ram8x16_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             a2,
   input  logic             a1,
   input  logic             a0,
   output logic [WIDTH-1:0] out
);

   logic [ADDR_W-1:0] w_addr;
   sel_t              w_sel;
   logic [WIDTH-1:0]  w_q [NWORDS];

   assign w_addr = {a2, a1, a0};

   always_comb begin
      w_sel = '0;
      case (w_addr)
         3'd0:    w_sel = 8'b0000_0001;
         3'd1:    w_sel = 8'b0000_0010;
         3'd2:    w_sel = 8'b0000_0100;
         3'd3:    w_sel = 8'b0000_1000;
         3'd4:    w_sel = 8'b0001_0000;
         3'd5:    w_sel = 8'b0010_0000;
         3'd6:    w_sel = 8'b0100_0000;
         3'd7:    w_sel = 8'b1000_0000;
         default: w_sel = '0;
      endcase
   end

   // No write strobe: the addressed word is loaded on every non-reset edge.
   for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
      ram8x16_word #(
         .WIDTH (WIDTH)
      ) u_word (
         .clk (clk),
         .rst (rst),
         .en  (w_sel[gi]),
         .d   (d),
         .q   (w_q[gi])
      );
   end

   always_comb begin
      out = '0;
      case (w_addr)
         3'd0:    out = w_q[0];
         3'd1:    out = w_q[1];
         3'd2:    out = w_q[2];
         3'd3:    out = w_q[3];
         3'd4:    out = w_q[4];
         3'd5:    out = w_q[5];
         3'd6:    out = w_q[6];
         3'd7:    out = w_q[7];
         default: out = '0;
      endcase
   end

endmodule : ram8x16_core

// File: tb/tb_ram8x16_core.sv
// tb/tb_ram8x16_core.sv - directed bench for ram8x16_core
module tb_ram8x16_core;

   logic        clk;
   logic        rst;
   logic [15:0] d;
   logic        a2;
   logic        a1;
   logic        a0;
   logic [15:0] out;

   int n_tests;
   int n_fail;

   ram8x16_core #(
      .WIDTH (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .a2  (a2),
      .a1  (a1),
      .a0  (a0),
      .out (out)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic set_addr(input int a);
      logic [2:0] av;
      av = a[2:0];
      {a2, a1, a0} = av;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic read_at(input string tag, input int a, input logic [15:0] exp);
      set_addr(a);
      #1;
      check($sformatf("%s_a%0d", tag, a), out, exp);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      d   = 16'h0000;
      set_addr(0);

      // reset for two edges, then sweep with no edges in between
      edge_step();
      edge_step();
      for (int i = 0; i < 8; i++) read_at("reset", i, 16'h0000);

      // single write of 100 to address 1
      rst = 1'b0;
      d   = 16'd100;
      set_addr(1);
      edge_step();
      check("wr1", out, 16'd100);
      read_at("wr1_other", 0, 16'h0000);
      read_at("wr1_other", 7, 16'h0000);
      read_at("wr1_back", 1, 16'd100);

      // d alone must not reach out
      d = 16'hBEEF;
      #1;
      check("d_no_comb", out, 16'd100);

      // repeated write, other words untouched
      d = 16'd100;
      set_addr(1);
      edge_step();
      edge_step();
      check("rep", out, 16'd100);
      for (int i = 0; i < 8; i++) if (i != 1) read_at("rep_other", i, 16'h0000);

      // second address
      d = 16'd1;
      set_addr(7);
      #1;
      check("rdw_before", out, 16'h0000);
      edge_step();
      check("wr7", out, 16'd1);
      read_at("wr7_a1", 1, 16'd100);

      // full sweep
      for (int i = 0; i < 8; i++) begin
         d = 16'hA000 + 16'(i);
         set_addr(i);
         edge_step();
      end
      for (int i = 0; i < 8; i++) read_at("sweep", i, 16'hA000 + 16'(i));

      d = 16'hFFFF;
      set_addr(3);
      edge_step();
      for (int i = 0; i < 8; i++)
         read_at("ovr3", i, (i == 3) ? 16'hFFFF : 16'hA000 + 16'(i));

      // reset priority over the write in the same cycle
      rst = 1'b1;
      d   = 16'h1234;
      set_addr(5);
      edge_step();
      for (int i = 0; i < 8; i++) read_at("rstpri", i, 16'h0000);

      rst = 1'b0;
      d   = 16'h1234;
      set_addr(5);
      edge_step();
      check("resume5", out, 16'h1234);
      read_at("resume_other", 4, 16'h0000);
      read_at("resume_back", 5, 16'h1234);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ram8x16_core
